// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns PS/2 Set-2 scan-code bytes into four sensor flags for the alarm
//   control FSM. Plain make codes set a flag. F0-prefixed break codes clear it.
//   E0-prefixed extended codes are swallowed. If a prefix byte is received and
//   no follow-up byte arrives, a timeout returns the decoder to IDLE.
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   rx_done_tick in   one-cycle strobe, dout holds a valid byte
//   dout         in   received PS/2 byte
//   T0/T1/H1/E   out  sensor flags, each high while its key is held
//   code_reg     out  last non-extended make code accepted
//   key_tick     out  one-cycle strobe per decoded make or break
module ps2_scancode_decoder #(
  parameter logic [7:0] KEY_T0         = 8'h16,
  parameter logic [7:0] KEY_T1         = 8'h1E,
  parameter logic [7:0] KEY_H1         = 8'h33,
  parameter logic [7:0] KEY_E          = 8'h24,
  parameter logic [7:0] KEY_CLR        = 8'h76,
  parameter int         TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] dout,
  output logic       T0,
  output logic       T1,
  output logic       H1,
  output logic       E,
  output logic [7:0] code_reg,
  output logic       key_tick
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] BYTE_BRK = 8'hF0;
  localparam logic [7:0] BYTE_EXT = 8'hE0;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       flags_q, flags_d;   // {T0, T1, H1, E}
  logic [7:0]       code_q, code_d;
  logic             tick_q, tick_d;

  // One-hot flag position for a scan code; zero for codes that drive no flag.
  function automatic logic [3:0] key_mask(input logic [7:0] b);
    logic [3:0] m;
    m = 4'b0000;
    if (b == KEY_T0) m[3] = 1'b1;
    if (b == KEY_T1) m[2] = 1'b1;
    if (b == KEY_H1) m[1] = 1'b1;
    if (b == KEY_E)  m[0] = 1'b1;
    return m;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    flags_d = flags_q;
    code_d  = code_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_done_tick) begin
          if (dout == BYTE_BRK) begin
            state_d = BRK;
          end else if (dout == BYTE_EXT) begin
            state_d = EXT;
          end else begin
            code_d = dout;
            tick_d = 1'b1;
            if (dout == KEY_CLR) flags_d = 4'b0000;
            else                 flags_d = flags_q | key_mask(dout);
          end
        end
      end
      BRK: begin
        if (rx_done_tick) begin
          state_d = IDLE;
          // A second prefix here is malformed; drop it without a tick.
          if (dout != BYTE_BRK && dout != BYTE_EXT) begin
            tick_d  = 1'b1;
            flags_d = flags_q & ~key_mask(dout);
          end
        end
      end
      EXT: begin
        if (rx_done_tick) state_d = (dout == BYTE_BRK) ? EXT_BRK : IDLE;
      end
      EXT_BRK: begin
        if (rx_done_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A byte always beats an expiring timeout, so only idle cycles count.
    if (state_q != IDLE && !rx_done_tick) begin
      if (cnt_q == CNT_MAX) state_d = IDLE;
      else                  cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flags_q <= 4'b0000;
      code_q  <= 8'h00;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      code_q  <= code_d;
      tick_q  <= tick_d;
    end
  end

  assign T0       = flags_q[3];
  assign T1       = flags_q[2];
  assign H1       = flags_q[1];
  assign E        = flags_q[0];
  assign code_reg = code_q;
  assign key_tick = tick_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] dout = 8'h00;
  logic       T0, T1, H1, E, key_tick;
  logic [7:0] code_reg;
  logic [3:0] flags;

  int n_checks = 0;
  int n_fail   = 0;

  assign flags = {T0, T1, H1, E};

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .dout(dout),
    .T0(T0), .T1(T1), .H1(H1), .E(E), .code_reg(code_reg), .key_tick(key_tick)
  );

  always #5 clk = ~clk;

  // Called at a negedge: presents the byte for the next posedge and returns
  // at the following negedge, where the registered result is visible.
  task automatic send_byte(input logic [7:0] b);
    rx_done_tick = 1'b1;
    dout = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    rx_done_tick = 1'b1;
    dout = 8'h16;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({flags, code_reg, key_tick} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got flags=%b code=%h tick=%b, want all 0", flags, code_reg, key_tick);
    end
    rx_done_tick = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_make();
    send_byte(8'h16);
    n_checks++;
    if (flags !== 4'b1000 || code_reg !== 8'h16 || key_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL make_16: got flags=%b code=%h tick=%b, want 1000 16 1", flags, code_reg, key_tick);
    end
    @(negedge clk);
    n_checks++;
    if (key_tick !== 1'b0 || flags !== 4'b1000) begin
      n_fail++;
      $display("FAIL tick_one_cycle: got tick=%b flags=%b, want 0 1000", key_tick, flags);
    end
  endtask

  task automatic test_repeat_break();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h16);
      n_checks++;
      if (flags !== 4'b1000 || key_tick !== 1'b1) begin
        n_fail++;
        $display("FAIL typematic_%0d: got flags=%b tick=%b, want 1000 1", i, flags, key_tick);
      end
    end
    send_byte(8'hF0);
    n_checks++;
    if (flags !== 4'b1000 || key_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL break_prefix: got flags=%b tick=%b, want 1000 0", flags, key_tick);
    end
    send_byte(8'h16);
    n_checks++;
    if (flags !== 4'b0000 || code_reg !== 8'h16 || key_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL break_16: got flags=%b code=%h tick=%b, want 0000 16 1", flags, code_reg, key_tick);
    end
  endtask

  task automatic test_multi_clear();
    send_byte(8'h1E);
    send_byte(8'h33);
    send_byte(8'h24);
    n_checks++;
    if (flags !== 4'b0111 || code_reg !== 8'h24) begin
      n_fail++;
      $display("FAIL multi_flags: got flags=%b code=%h, want 0111 24", flags, code_reg);
    end
    send_byte(8'h76);
    n_checks++;
    if (flags !== 4'b0000 || code_reg !== 8'h76 || key_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_all: got flags=%b code=%h tick=%b, want 0000 76 1", flags, code_reg, key_tick);
    end
  endtask

  task automatic test_extended();
    send_byte(8'h16);
    send_byte(8'hE0);
    send_byte(8'h1E);
    n_checks++;
    if (flags !== 4'b1000 || code_reg !== 8'h16 || key_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_make: got flags=%b code=%h tick=%b, want 1000 16 0", flags, code_reg, key_tick);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h16);
    n_checks++;
    if (flags !== 4'b1000 || code_reg !== 8'h16 || key_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_break: got flags=%b code=%h tick=%b, want 1000 16 0", flags, code_reg, key_tick);
    end
    send_byte(8'h24);
    n_checks++;
    if (flags !== 4'b1001 || code_reg !== 8'h24 || key_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL ext_back_idle: got flags=%b code=%h tick=%b, want 1001 24 1", flags, code_reg, key_tick);
    end
    send_byte(8'h76);
  endtask

  task automatic test_brk_prefix();
    send_byte(8'hF0);
    send_byte(8'hF0);
    n_checks++;
    if (key_tick !== 1'b0 || flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL brk_discard: got tick=%b flags=%b, want 0 0000", key_tick, flags);
    end
    send_byte(8'h33);
    n_checks++;
    if (flags !== 4'b0010 || code_reg !== 8'h33 || key_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL brk_discard_make: got flags=%b code=%h tick=%b, want 0010 33 1", flags, code_reg, key_tick);
    end
    send_byte(8'hF0);
    send_byte(8'h5A);
    n_checks++;
    if (flags !== 4'b0010 || code_reg !== 8'h33 || key_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL unmapped_break: got flags=%b code=%h tick=%b, want 0010 33 1", flags, code_reg, key_tick);
    end
    send_byte(8'h76);
  endtask

  task automatic test_timeout();
    // Prefix, then 8 idle cycles: the timeout has fired, so 16 is a make.
    send_byte(8'hF0);
    repeat (8) @(negedge clk);
    send_byte(8'h16);
    n_checks++;
    if (flags !== 4'b1000 || code_reg !== 8'h16 || key_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_make: got flags=%b code=%h tick=%b, want 1000 16 1", flags, code_reg, key_tick);
    end
    send_byte(8'h24);
    // Prefix, then 7 idle cycles: the byte lands on the expiry cycle.
    send_byte(8'hF0);
    repeat (7) @(negedge clk);
    send_byte(8'h16);
    n_checks++;
    if (flags !== 4'b0001 || code_reg !== 8'h24 || key_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_edge_break: got flags=%b code=%h tick=%b, want 0001 24 1", flags, code_reg, key_tick);
    end
    send_byte(8'h76);
  endtask

  task automatic test_reset_mid_brk();
    send_byte(8'h33);
    send_byte(8'hF0);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({flags, code_reg, key_tick} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_mid_brk: got flags=%b code=%h tick=%b, want all 0", flags, code_reg, key_tick);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_byte(8'h33);
    n_checks++;
    if (flags !== 4'b0010 || code_reg !== 8'h33 || key_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_make: got flags=%b code=%h tick=%b, want 0010 33 1", flags, code_reg, key_tick);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_repeat_break();
    test_multi_clear();
    test_extended();
    test_brk_prefix();
    test_timeout();
    test_reset_mid_brk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
